// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: edge-latched, maskable, highest-index-wins interrupt controller with ack/EOI handshake
module irq_priority_ctrl #(
    parameter int N_CH = 16,
    parameter int ID_W = $clog2(N_CH),
    parameter int AW = 32,
    parameter logic [AW-1:0] VEC_BASE = AW'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic [N_CH-1:0] irq_in,
    input  logic            int_en,
    input  logic            mask_we,
    input  logic [N_CH-1:0] mask_wdata,
    input  logic            ack,
    input  logic            eoi,
    input  logic            ovr_clr,
    output logic            irq_req,
    output logic [ID_W-1:0] irq_id,
    output logic [AW-1:0]   irq_vec,
    output logic [N_CH-1:0] pending,
    output logic [7:0]      status
);
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, SVC = 2'b10} state_t;
    state_t          state;
    logic [N_CH-1:0] irq_prev, mask, rise, unm, clr, svc;
    logic [ID_W-1:0] win;
    logic            overrun;
    assign rise   = irq_in & ~irq_prev;
    assign unm    = pending & ~mask;
    assign clr    = (state == REQ && ack) ? (N_CH'(1) << irq_id) : '0;
    assign svc    = (state == SVC) ? (N_CH'(1) << irq_id) : '0;
    assign status = {int_en, state, |unm, overrun, 3'b000};
    always_comb begin
        win = '0;
        for (int i = 0; i < N_CH; i++)
            if (unm[i]) win = ID_W'(i);
    end
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pending  <= '0;
            irq_prev <= '0;
            mask     <= '1;
            state    <= IDLE;
            irq_req  <= 1'b0;
            irq_id   <= '0;
            irq_vec  <= VEC_BASE;
            overrun  <= 1'b0;
        end else begin
            irq_prev <= irq_in;
            pending  <= (pending & ~clr) | rise;
            overrun  <= |(rise & (pending | svc)) | (overrun & ~ovr_clr);
            if (mask_we) mask <= mask_wdata;
            case (state)
                IDLE: if (int_en && |unm) begin
                    state   <= REQ;
                    irq_req <= 1'b1;
                    irq_id  <= win;
                    irq_vec <= VEC_BASE + (AW'(win) << 2);
                end
                REQ: if (ack) begin
                    state   <= SVC;
                    irq_req <= 1'b0;
                end
                SVC: if (eoi) state <= IDLE;
                default: begin
                    state   <= IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_priority_ctrl.sv
// tb_irq_priority_ctrl: directed scenarios plus random traffic, checked every cycle against a behavioural model
module tb_irq_priority_ctrl;
    localparam int N = 16;
    logic         clk = 0, rstN = 0;
    logic [N-1:0] irq_in = '0, mask_wdata = '0;
    logic         int_en = 0, mask_we = 0, ack = 0, eoi = 0, ovr_clr = 0;
    logic         irq_req;
    logic [3:0]   irq_id;
    logic [31:0]  irq_vec;
    logic [N-1:0] pending;
    logic [7:0]   status;
    int n_chk = 0, n_fail = 0;
    bit [N-1:0] m_pend, m_prev, m_mask;
    int         m_st, m_id;
    bit         m_ovr;

    irq_priority_ctrl dut (
        .clk(clk), .rstN(rstN), .irq_in(irq_in), .int_en(int_en), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .ack(ack), .eoi(eoi), .ovr_clr(ovr_clr), .irq_req(irq_req),
        .irq_id(irq_id), .irq_vec(irq_vec), .pending(pending), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pend = '0; m_prev = '0; m_mask = '1; m_st = 0; m_id = 0; m_ovr = 0;
    endtask

    task automatic m_step();
        bit [N-1:0] rise, nxt;
        bit         set;
        int         win;
        if (!rstN) begin
            m_reset();
            return;
        end
        win = -1;
        for (int i = 0; i < N; i++) if (m_pend[i] && !m_mask[i]) win = i;
        rise = irq_in & ~m_prev;
        set = 0;
        for (int i = 0; i < N; i++)
            if (rise[i] && (m_pend[i] || (m_st == 2 && m_id == i))) set = 1;
        nxt = m_pend;
        if (m_st == 1 && ack) nxt[m_id] = 0;
        nxt |= rise;
        if (m_st == 0) begin
            if (int_en && win >= 0) begin m_st = 1; m_id = win; end
        end else if (m_st == 1) begin
            if (ack) m_st = 2;
        end else if (eoi) m_st = 0;
        m_ovr = set ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
        if (mask_we) m_mask = mask_wdata;
        m_pend = nxt;
        m_prev = irq_in;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    always @(negedge clk) if (rstN) begin
        chk("pending", pending, m_pend);
        chk("irq_req", irq_req, m_st == 1);
        chk("irq_id", irq_id, m_id);
        chk("irq_vec", irq_vec, 32'h100 + m_id * 4);
        chk("status", status, {int_en, m_st[1:0], |(m_pend & ~m_mask), m_ovr, 3'b000});
    end

    initial begin
        m_reset();
        repeat (2) tick();
        rstN = 1;
        tick();
        chk("rst_pending", pending, 0);
        chk("rst_vec", irq_vec, 32'h100);
        chk("rst_status", status, 8'h00);
        // single channel
        int_en = 1; mask_we = 1; mask_wdata = '0; tick(); mask_we = 0;
        irq_in[3] = 1; tick();
        chk("t2_pending", pending, 16'h0008);
        chk("t2_req_early", irq_req, 0);
        tick();
        chk("t2_req", irq_req, 1);
        chk("t2_id", irq_id, 3);
        chk("t2_vec", irq_vec, 32'h10C);
        chk("t2_status_req", status, 8'hB0);
        ack = 1; tick(); ack = 0;
        chk("t2_pend_clr", pending, 0);
        chk("t2_status_svc", status, 8'hC0);
        irq_in = '0; eoi = 1; tick(); eoi = 0;
        chk("t2_status_idle", status, 8'h80);
        // reset during service
        irq_in[4] = 1; tick(); tick(); ack = 1; tick(); ack = 0;
        chk("t1_in_svc", status[6:5], 2'b10);
        #2 rstN = 0; m_reset(); #1;
        chk("t1_req", irq_req, 0);
        chk("t1_pending", pending, 0);
        chk("t1_status", status, 8'h80);
        tick(); rstN = 1; irq_in = '0; tick(); tick();
        chk("t1_mask_all", irq_req, 0);
        // priority
        mask_we = 1; mask_wdata = 16'h8000; tick(); mask_we = 0;
        irq_in = 16'h8204; tick(); tick();
        chk("t3_id9", irq_id, 9);
        ack = 1; tick(); ack = 0; eoi = 1; tick(); eoi = 0; tick();
        chk("t3_id2", irq_id, 2);
        ack = 1; tick(); ack = 0; eoi = 1; tick(); eoi = 0;
        irq_in = '0; tick(); irq_in[9] = 1; tick(); tick();
        mask_we = 1; mask_wdata = '0; tick(); mask_we = 0;
        chk("t3_frozen", irq_id, 9);
        ack = 1; tick(); ack = 0; eoi = 1; tick(); eoi = 0; tick();
        chk("t3_id15", irq_id, 15);
        ack = 1; tick(); ack = 0; eoi = 1; tick(); eoi = 0; irq_in = '0; tick();
        // overrun
        irq_in[5] = 1; tick(); irq_in[5] = 0; tick(); irq_in[5] = 1; tick();
        chk("t4_ovr", status[3], 1);
        ack = 1; tick(); ack = 0; eoi = 1; tick(); eoi = 0; tick();
        chk("t4_one_service", irq_req, 0);
        ovr_clr = 1; tick(); ovr_clr = 0;
        chk("t4_ovr_clr", status[3], 0);
        irq_in = '0; tick();
        // gating
        int_en = 0; irq_in[1] = 1; tick(); tick();
        chk("t5_gated", irq_req, 0);
        chk("t5_any", status[4], 1);
        int_en = 1; tick();
        chk("t5_req", irq_req, 1);
        irq_in = '0;
        // handshake abuse
        ack = 1; tick(); ack = 0; tick();
        ack = 1; tick(); ack = 0;
        chk("t6_ack_svc", status[6:5], 2'b10);
        eoi = 1; tick(); eoi = 0;
        ack = 1; tick(); ack = 0;
        chk("t6_ack_idle", irq_req, 0);
        irq_in[7] = 1; tick(); irq_in[7] = 0; tick();
        eoi = 1; tick(); eoi = 0;
        chk("t6_eoi_req", irq_req, 1);
        irq_in[7] = 1; ack = 1; tick(); ack = 0;
        chk("t6_same_edge_pend", pending[7], 1);
        chk("t6_same_edge_ovr", status[3], 1);
        eoi = 1; tick(); eoi = 0; irq_in = '0; ovr_clr = 1; tick(); ovr_clr = 0;
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(15) == 0) irq_in[i] = ~irq_in[i];
            ack = $urandom_range(2) == 0;
            eoi = $urandom_range(2) == 0;
            mask_we = $urandom_range(15) == 0;
            mask_wdata = N'($urandom);
            int_en = $urandom_range(7) != 0;
            ovr_clr = $urandom_range(7) == 0;
            if ($urandom_range(499) == 0) begin
                #2 rstN = 0; m_reset(); #1;
                chk("rnd_rst_req", irq_req, 0);
                tick(); rstN = 1;
            end
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
